// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle MIPS-subset core on one shared req/ack memory port
// Optional mul (R-type funct 0x18) is built only when MULTICYCLE_CPU_MUL_EN is defined.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 32,
    parameter int          NREGS    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halt_o,
    output logic [2:0]        state_o
);

    localparam int RW = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
`ifdef MULTICYCLE_CPU_MUL_EN
    localparam logic [5:0] FN_MUL = 6'h18;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [31:0]         ir_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [31:0]         alu_q;
    logic [31:0]         mdr_q;
    logic [31:0]         regs_q [NREGS];
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                halt_q;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] wb_idx_d;
    logic [31:0]   wb_data_d;
    logic [31:0]   sext_imm;
    logic [31:0]   pc32;
    logic [31:0]   branch_target_d;
    logic [31:0]   jump_target_d;
    logic [31:0]   imm_sum_d;
    logic [31:0]   r_result_d;
    logic          r_legal;
    logic          instr_legal;
    logic          unused_bits;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RW];
    assign rt_idx   = ir_q[16 +: RW];
    assign rd_idx   = ir_q[11 +: RW];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc32     = 32'(pc_q);

    assign branch_target_d = pc32 + (sext_imm << 2);
    assign jump_target_d   = {pc32[31:28], ir_q[25:0], 2'b00};
    assign imm_sum_d       = a_q + sext_imm;

    assign wb_idx_d  = (opcode == OP_R) ? rd_idx : rt_idx;
    assign wb_data_d = (opcode == OP_LW) ? mdr_q : alu_q;

    // Shamt and, for small register files, the upper specifier bits are ignored.
    assign unused_bits = ^{ir_q, alu_q};

    always_comb begin
        r_result_d = a_q + b_q;
        r_legal    = 1'b1;
        case (funct)
            FN_ADD:  r_result_d = a_q + b_q;
            FN_SUB:  r_result_d = a_q - b_q;
            FN_AND:  r_result_d = a_q & b_q;
            FN_OR:   r_result_d = a_q | b_q;
            FN_SLT:  r_result_d = {31'b0, $signed(a_q) < $signed(b_q)};
`ifdef MULTICYCLE_CPU_MUL_EN
            // Low half of a product is the same for signed and unsigned operands.
            FN_MUL:  r_result_d = a_q * b_q;
`endif
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_R:                                 instr_legal = r_legal;
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: instr_legal = 1'b1;
            default:                              instr_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC_W;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halt_q      <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q & ALIGN_MASK;
                    end
                end
                S_FETCH: begin
                    // Entered straight from a store ack with the port idle: raise the fetch now.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q & ALIGN_MASK;
                    end else if (mem_ack_i) begin
                        ir_q      <= mem_rdata_i;
                        pc_q      <= pc_q + ADDR_W'(4);
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= regs_q[rs_idx];
                    b_q   <= regs_q[rt_idx];
                    alu_q <= branch_target_d;
                    if (instr_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_q   <= r_result_d;
                            state_q <= S_WB;
                        end
                        OP_ADDI: begin
                            alu_q   <= imm_sum_d;
                            state_q <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_q       <= imm_sum_d;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (opcode == OP_SW);
                            mem_addr_q  <= imm_sum_d[ADDR_W-1:0] & ALIGN_MASK;
                            mem_wdata_q <= b_q;
                            state_q     <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (a_q == b_q) begin
                                pc_q       <= alu_q[ADDR_W-1:0];
                                mem_addr_q <= alu_q[ADDR_W-1:0] & ALIGN_MASK;
                            end else begin
                                mem_addr_q <= pc_q & ALIGN_MASK;
                            end
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            state_q   <= S_FETCH;
                        end
                        OP_J: begin
                            pc_q       <= jump_target_d[ADDR_W-1:0];
                            mem_addr_q <= jump_target_d[ADDR_W-1:0] & ALIGN_MASK;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            state_q    <= S_FETCH;
                        end
                        default: begin
                            state_q <= S_HALT;
                            halt_q  <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (opcode == OP_LW) begin
                            mdr_q   <= mem_rdata_i;
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx_d != '0) begin
                        regs_q[wb_idx_d] <= wb_data_d;
                    end
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q & ALIGN_MASK;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                    halt_q    <= 1'b1;
                end
                default: begin
                    state_q   <= S_HALT;
                    mem_req_q <= 1'b0;
                    halt_q    <= 1'b1;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign pc_o        = pc_q;
    assign halt_o      = halt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - scoreboard bench for multicycle_cpu with a wait-state memory model
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic        halt_o;
    logic [2:0]  state_o;

    multicycle_cpu dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .pc_o        (pc_o),
        .halt_o      (halt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        sb [$];
    int          dec_t [$];
    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_n   = 0;
    int          wcnt     = 0;
    int          cyc      = 0;
    logic [2:0]  prev_state = 3'd0;
    logic        in_txn   = 1'b0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_t(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    task automatic push_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        sb.push_back(t);
    endtask

    task automatic push_fetches(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) push_txn(1'b0, first + 32'(4 * i), 32'h0);
    endtask

    // Memory responder plus request monitor: pops the scoreboard at each request start.
    always @(negedge clk) begin
        cyc++;
        if (state_o == 3'd2 && prev_state != 3'd2) dec_t.push_back(cyc);
        prev_state = state_o;
        if (mem_req_o && !mem_ack_i) begin
            if (!in_txn) begin
                txn_t e;
                in_txn    = 1'b1;
                cap_addr  = mem_addr_o;
                cap_wdata = mem_wdata_o;
                if (sb.size() == 0) begin
                    check("sb_extra_req", {31'b0, mem_req_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("sb_we", {31'b0, mem_we_o}, {31'b0, e.we});
                    check("sb_addr", mem_addr_o, e.addr);
                    if (e.we) check("sb_wdata", mem_wdata_o, e.wdata);
                end
            end
            if (wcnt >= wait_n) begin
                if (wait_n > 0) begin
                    check("hold_addr", mem_addr_o, cap_addr);
                    check("hold_wdata", mem_wdata_o, cap_wdata);
                end
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o[9:2]];
                if (mem_we_o) mem[mem_addr_o[9:2]] = mem_wdata_o;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
            in_txn    = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        dec_t.delete();
        @(negedge clk);
    endtask

    task automatic start_cpu();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halt_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, {31'b0, halt_o}, 32'h1);
        repeat (4) @(negedge clk);
        check({tag, "_state"}, 32'(state_o), 32'h6);
        check({tag, "_req_idle"}, {31'b0, mem_req_o}, 32'h0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    task automatic load_alu_prog();
        clear_mem();
        mem[0] = i_t(8, 0, 1, 5);
        mem[1] = i_t(8, 0, 2, -3);
        mem[2] = r_t(1, 2, 3, 'h20);
        mem[3] = r_t(2, 1, 4, 'h2A);
        mem[4] = r_t(0, 1, 5, 'h22);
        mem[5] = i_t('h2B, 0, 3, 'h80);
        mem[6] = i_t('h2B, 0, 4, 'h84);
        mem[7] = i_t('h2B, 0, 5, 'h88);
        mem[8] = ILLEGAL;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        clear_mem();
        repeat (2) @(negedge clk);

        // Reset state and start
        do_reset();
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", {31'b0, mem_req_o}, 32'h0);
        check("rst_we", {31'b0, mem_we_o}, 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_halt", {31'b0, halt_o}, 32'h0);

        // ALU sequence, zero-wait
        load_alu_prog();
        wait_n = 0;
        push_fetches(32'h0, 6);
        push_txn(1'b1, 32'h80, 32'd2);
        push_fetches(32'h18, 1);
        push_txn(1'b1, 32'h84, 32'd1);
        push_fetches(32'h1C, 1);
        push_txn(1'b1, 32'h88, 32'hFFFF_FFFB);
        push_fetches(32'h20, 1);
        start_cpu();
        check("start_state", 32'(state_o), 32'h1);
        check("start_req", {31'b0, mem_req_o}, 32'h1);
        wait_halt("alu");
        for (int i = 0; i < 5; i++) begin
            if (dec_t.size() > i + 1) check("alu_latency", 32'(dec_t[i+1] - dec_t[i]), 32'd4);
            else check("alu_latency_missing", 32'(dec_t.size()), 32'(i + 2));
        end
        check("alu_pc_after_halt", pc_o, 32'h24);

        // Store then load with 3 wait cycles per access
        clear_mem();
        mem[0] = i_t(8, 0, 1, 5);
        mem[1] = i_t(8, 0, 7, 'h100);
        mem[2] = i_t('h2B, 7, 1, 8);
        mem[3] = i_t('h23, 7, 6, 8);
        mem[4] = i_t('h2B, 0, 6, 'h94);
        mem[5] = ILLEGAL;
        wait_n = 3;
        do_reset();
        push_fetches(32'h0, 3);
        push_txn(1'b1, 32'h108, 32'd5);
        push_fetches(32'hC, 1);
        push_txn(1'b0, 32'h108, 32'h0);
        push_fetches(32'h10, 1);
        push_txn(1'b1, 32'h94, 32'd5);
        push_fetches(32'h14, 1);
        start_cpu();
        wait_halt("ldst");
        check("ldst_mem108", mem['h108 >> 2], 32'd5);
        check("ldst_mem94", mem['h94 >> 2], 32'd5);
        if (dec_t.size() > 4) check("lw_latency", 32'(dec_t[4] - dec_t[3]), 32'd11);
        else check("lw_latency_missing", 32'(dec_t.size()), 32'd5);

        // Branches, jump, $0 discard, illegal opcode
        clear_mem();
        mem[0]  = i_t(8, 0, 1, 1);
        mem[1]  = i_t(8, 0, 2, 2);
        mem[2]  = r_t(0, 0, 0, 'h20);
        mem[3]  = i_t(8, 0, 0, 7);
        mem[4]  = i_t(4, 1, 1, 2);
        mem[5]  = ILLEGAL;
        mem[6]  = ILLEGAL;
        mem[7]  = i_t(4, 1, 2, 4);
        mem[8]  = {6'h02, 26'h40};
        mem[64] = r_t(0, 0, 7, 'h20);
        mem[65] = i_t('h2B, 0, 7, 'h98);
        mem[66] = ILLEGAL;
        mem['h98 >> 2] = 32'hDEAD_BEEF;
        wait_n = 0;
        do_reset();
        push_fetches(32'h0, 5);
        push_fetches(32'h1C, 2);
        push_fetches(32'h100, 2);
        push_txn(1'b1, 32'h98, 32'h0);
        push_fetches(32'h108, 1);
        start_cpu();
        wait_halt("br");
        if (dec_t.size() > 7) begin
            check("addi_latency", 32'(dec_t[4] - dec_t[3]), 32'd4);
            check("beq_taken_latency", 32'(dec_t[5] - dec_t[4]), 32'd3);
            check("beq_nt_latency", 32'(dec_t[6] - dec_t[5]), 32'd3);
            check("j_latency", 32'(dec_t[7] - dec_t[6]), 32'd3);
        end else begin
            check("br_latency_missing", 32'(dec_t.size()), 32'd8);
        end
        check("br_mem98", mem['h98 >> 2], 32'h0);
        check("br_pc", pc_o, 32'h10C);

        // Reset during an unacknowledged fetch
        load_alu_prog();
        wait_n = 0;
        do_reset();
        push_fetches(32'h0, 3);
        start_cpu();
        for (int i = 0; i < 100 && dec_t.size() < 2; i++) @(negedge clk);
        wait_n = 100;
        for (int i = 0; i < 100 && !(state_o == 3'd1 && mem_req_o); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("midfetch_req", {31'b0, mem_req_o}, 32'h1);
        check("midfetch_pc", pc_o, 32'h8);
        rst_i = 1'b1;
        @(negedge clk);
        check("rstfetch_req", {31'b0, mem_req_o}, 32'h0);
        check("rstfetch_state", 32'(state_o), 32'h0);
        check("rstfetch_pc", pc_o, 32'h0);
        rst_i = 1'b0;
        wait_n = 0;
        repeat (4) @(negedge clk);
        check("rstfetch_idle", 32'(state_o), 32'h0);
        check("rstfetch_sb_empty", 32'(sb.size()), 32'h0);

        // mul (optional feature)
        clear_mem();
        mem[0] = i_t(8, 0, 1, -4);
        mem[1] = i_t(8, 0, 2, 6);
        mem[2] = r_t(1, 2, 3, 'h18);
        mem[3] = i_t('h2B, 0, 3, 'hA0);
        mem[4] = ILLEGAL;
        do_reset();
`ifdef MULTICYCLE_CPU_MUL_EN
        push_fetches(32'h0, 4);
        push_txn(1'b1, 32'hA0, 32'hFFFF_FFE8);
        push_fetches(32'h10, 1);
        start_cpu();
        wait_halt("mul");
        check("mul_memA0", mem['hA0 >> 2], 32'hFFFF_FFE8);
        check("mul_pc", pc_o, 32'h14);
`else
        push_fetches(32'h0, 3);
        start_cpu();
        wait_halt("mul");
        check("mul_pc", pc_o, 32'hC);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
